match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
- Sequences a two-player match around the game engine: arms each game, runs a between-games countdown, enables play, and credits the winner on `gameFinished`.
- Owns both score registers and declares the match winner at `WIN_SCORE`.
- Sits between the button/tick logic and the game engine; feeds the scores and countdown to the 7-segment display path.

Parameters:
- SCORE_W, 7, width of each score register.
- WIN_SCORE, 7, points needed to win the match; legal range 1..2^SCORE_W-1.
- PAUSE_TICKS, 3, slow ticks of countdown before each game; 0 means no countdown.
- CNT_W, 4, countdown counter width; must hold PAUSE_TICKS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetMatch  in  1  asynchronous, active-high reset of the whole match.
- tick  in  1  single-cycle slow enable (about 1 Hz), synchronous to clk.
- startBtn  in  1  single-cycle debounced start pulse.
- gameFinished  in  1  single-cycle pulse from the game engine when a game ends.
- lastWinner  in  1  0 = player 1, 1 = player 2; sampled only with gameFinished.
- gameReset  out  1  one-cycle pulse telling the engine to re-centre ball and paddles.
- gameRun  out  1  level enable for the game engine.
- player1_score  out  SCORE_W  player 1 games won.
- player2_score  out  SCORE_W  player 2 games won.
- countdown  out  CNT_W  remaining pause ticks, for display.
- matchOver  out  1  high while in OVER.
- matchWinner  out  1  winner of the finished match (0 = player 1, 1 = player 2); valid while matchOver is high.
- state  out  3  debug encoding of the FSM state.

Behaviour:
- **Reset:** on async reset assertion, all of the following take effect immediately and hold while reset is high:
  - state = IDLE
  - player1_score = player2_score = 0
  - countdown = 0
  - gameReset = 0, gameRun = 0
  - matchOver = 0, matchWinner = 0
- **State encoding and outputs:** all outputs are registered or Moore-decoded from state; no combinational input-to-output paths.
  - IDLE = 0: waits for startBtn, then goes to LOAD.
  - LOAD = 1: gameReset = 1 for exactly this one cycle.
    - countdown is loaded with PAUSE_TICKS.
    - Next state is COUNT, or PLAY when PAUSE_TICKS = 0.
  - COUNT = 2: on each tick, countdown decrements.
    - A tick with countdown == 1 sets countdown to 0 and moves to PLAY.
    - Cycles without tick hold the state and count.
  - PLAY = 3: gameRun = 1. When gameFinished is seen in cycle N:
    - At N+1 the score of the player named by lastWinner has incremented by 1, and the state is CHECK.
    - gameRun is 0 from N+1 onward.
  - CHECK = 4: one cycle.
    - If the winner's score == WIN_SCORE: go to OVER and latch matchWinner = that player. matchOver is high from N+2.
    - Otherwise go to LOAD, so the next game auto-arms with gameReset at N+2.
  - OVER = 5: scores are frozen and matchOver = 1.
    - startBtn clears both scores and matchWinner, drops matchOver, and goes to LOAD.
- **Ignored inputs:**
  - gameFinished in any state other than PLAY, including a second pulse during CHECK.
  - startBtn in LOAD, COUNT, PLAY and CHECK.
  - tick outside COUNT.
- **Simultaneous events:**
  - tick and gameFinished in the same PLAY cycle: the score is credited; tick has no effect.
  - startBtn and tick in the same IDLE/OVER cycle: startBtn is taken.
- **Arithmetic:** scores are unsigned and increment by 1. Because a score can never exceed WIN_SCORE, no wrap is possible; no saturation logic is needed beyond the equality check.
- **Unused encodings:** states 6 and 7 return to IDLE on the next clock.
- **Reset mid-operation:** resetMatch in any state (including mid-countdown or PLAY) behaves exactly as reset:
  - gameRun drops asynchronously.
  - Scores are cleared; no partial credit.
- **Release:** after resetMatch deasserts, the FSM sits in IDLE until the first startBtn.

Test Plan:
1. Reset, then startBtn with PAUSE_TICKS=3 → gameReset is high for 1 cycle; countdown shows 3,2,1 on successive ticks; gameRun rises in the cycle after the third tick's edge.
2. In PLAY, gameFinished with lastWinner=1 → player2_score goes 0→1 one cycle later; gameRun drops; gameReset pulses 2 cycles after the pulse and the countdown restarts at 3; player1_score stays 0.
3. Drive 7 wins for player 1 with WIN_SCORE=7 → after the 7th, player1_score=7, matchOver=1, matchWinner=0; further gameFinished or tick pulses change nothing; startBtn clears both scores to 0 and re-enters LOAD.
4. Pulse gameFinished during COUNT and during IDLE → scores unchanged; state unchanged.
5. Assert resetMatch asynchronously (between edges) during PLAY with scores 3/2 → gameRun, scores and countdown are 0 before the next edge; state=IDLE; a startBtn is needed to resume.
6. PAUSE_TICKS=0 build: startBtn → LOAD for 1 cycle, then PLAY directly; tick and gameFinished in the same PLAY cycle credit exactly one point.

Source files
------------

// File: rtl/match_sequencer.sv
// Two-player match sequencer: arms each game, runs the pre-game countdown,
// credits the game winner and declares the match winner at WIN_SCORE.
module match_sequencer #(
    parameter int SCORE_W     = 7,
    parameter int WIN_SCORE   = 7,
    parameter int PAUSE_TICKS = 3,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               resetMatch,
    input  logic               tick,
    input  logic               startBtn,
    input  logic               gameFinished,
    input  logic               lastWinner,
    output logic               gameReset,
    output logic               gameRun,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic [CNT_W-1:0]   countdown,
    output logic               matchOver,
    output logic               matchWinner,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COUNT = 3'd2,
        PLAY  = 3'd3,
        CHECK = 3'd4,
        OVER  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               winner_q, winner_d;
    logic               grst_q, grst_d;
    logic               grun_q, grun_d;
    logic               over_q, over_d;
    logic [SCORE_W-1:0] last_score;

    assign last_score = last_q ? p2_q : p1_q;

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        winner_d = winner_q;
        case (state_q)
            IDLE: begin
                if (startBtn) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = CNT_W'(PAUSE_TICKS);
                state_d = (PAUSE_TICKS == 0) ? PLAY : COUNT;
            end
            COUNT: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = PLAY;
                end
            end
            PLAY: begin
                if (gameFinished) begin
                    last_d  = lastWinner;
                    state_d = CHECK;
                    if (lastWinner) p2_d = p2_q + SCORE_W'(1);
                    else            p1_d = p1_q + SCORE_W'(1);
                end
            end
            CHECK: begin
                if (last_score == SCORE_W'(WIN_SCORE)) begin
                    state_d  = OVER;
                    winner_d = last_q;
                end else begin
                    state_d = LOAD;
                end
            end
            OVER: begin
                if (startBtn) begin
                    p1_d     = '0;
                    p2_d     = '0;
                    winner_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        grst_d = (state_d == LOAD);
        grun_d = (state_d == PLAY);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge resetMatch) begin
        if (resetMatch) begin
            state_q  <= IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            winner_q <= 1'b0;
            grst_q   <= 1'b0;
            grun_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            grst_q   <= grst_d;
            grun_q   <= grun_d;
            over_q   <= over_d;
        end
    end

    assign gameReset     = grst_q;
    assign gameRun       = grun_q;
    assign player1_score = p1_q;
    assign player2_score = p2_q;
    assign countdown     = cnt_q;
    assign matchOver     = over_q;
    assign matchWinner   = winner_q;
    assign state         = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: a PAUSE_TICKS=3 instance and a PAUSE_TICKS=0
// instance, each checked every cycle against a match-level model.
module tb_match_sequencer;

    localparam int WIN = 7;

    logic       clk = 1'b0;
    logic       resetMatch = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] tick = '0;
    logic [1:0] gf = '0;
    logic [1:0] lw = '0;

    logic [1:0] grst, grun, mo, mw;
    logic [6:0] p1 [2];
    logic [6:0] p2 [2];
    logic [3:0] cd [2];
    logic [2:0] st [2];

    int checks = 0;
    int failures = 0;

    // model: phase codes follow the published debug encoding of `state`
    int m_ph [2];
    int m_sc [2][2];
    int m_cd [2];
    int m_mw [2];
    int m_lw [2];

    always #5 clk = ~clk;

    match_sequencer #(.PAUSE_TICKS(3)) u0 (
        .clk(clk), .resetMatch(resetMatch), .tick(tick[0]),
        .startBtn(start[0]), .gameFinished(gf[0]), .lastWinner(lw[0]),
        .gameReset(grst[0]), .gameRun(grun[0]),
        .player1_score(p1[0]), .player2_score(p2[0]),
        .countdown(cd[0]), .matchOver(mo[0]), .matchWinner(mw[0]),
        .state(st[0])
    );

    match_sequencer #(.PAUSE_TICKS(0)) u1 (
        .clk(clk), .resetMatch(resetMatch), .tick(tick[1]),
        .startBtn(start[1]), .gameFinished(gf[1]), .lastWinner(lw[1]),
        .gameReset(grst[1]), .gameRun(grun[1]),
        .player1_score(p1[1]), .player2_score(p2[1]),
        .countdown(cd[1]), .matchOver(mo[1]), .matchWinner(mw[1]),
        .state(st[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int pause;
        pause = (k == 0) ? 3 : 0;
        if (resetMatch) begin
            m_ph[k] = 0;
            m_sc[k][0] = 0;
            m_sc[k][1] = 0;
            m_cd[k] = 0;
            m_mw[k] = 0;
        end else if (m_ph[k] == 0) begin
            if (start[k]) m_ph[k] = 1;
        end else if (m_ph[k] == 1) begin
            m_cd[k] = pause;
            m_ph[k] = (pause == 0) ? 3 : 2;
        end else if (m_ph[k] == 2) begin
            if (tick[k]) begin
                m_cd[k] = m_cd[k] - 1;
                if (m_cd[k] == 0) m_ph[k] = 3;
            end
        end else if (m_ph[k] == 3) begin
            if (gf[k]) begin
                m_lw[k] = int'(lw[k]);
                m_sc[k][m_lw[k]] = m_sc[k][m_lw[k]] + 1;
                m_ph[k] = 4;
            end
        end else if (m_ph[k] == 4) begin
            if (m_sc[k][m_lw[k]] == WIN) begin
                m_ph[k] = 5;
                m_mw[k] = m_lw[k];
            end else begin
                m_ph[k] = 1;
            end
        end else if (m_ph[k] == 5) begin
            if (start[k]) begin
                m_sc[k][0] = 0;
                m_sc[k][1] = 0;
                m_mw[k] = 0;
                m_ph[k] = 1;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_sc[k][0] = 0; m_sc[k][1] = 0;
            m_cd[k] = 0; m_mw[k] = 0; m_lw[k] = 0;
        end
        forever begin
            @(posedge clk or posedge resetMatch);
            model_step(0);
            model_step(1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.state", k), int'(st[k]), m_ph[k]);
                check($sformatf("u%0d.gameReset", k), int'(grst[k]), int'(m_ph[k] == 1));
                check($sformatf("u%0d.gameRun", k), int'(grun[k]), int'(m_ph[k] == 3));
                check($sformatf("u%0d.matchOver", k), int'(mo[k]), int'(m_ph[k] == 5));
                check($sformatf("u%0d.matchWinner", k), int'(mw[k]), m_mw[k]);
                check($sformatf("u%0d.p1", k), int'(p1[k]), m_sc[k][0]);
                check($sformatf("u%0d.p2", k), int'(p2[k]), m_sc[k][1]);
                check($sformatf("u%0d.countdown", k), int'(cd[k]), m_cd[k]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic p_start(input int k);
        start[k] = 1'b1; cyc(1); start[k] = 1'b0;
    endtask

    task automatic p_tick(input int k);
        tick[k] = 1'b1; cyc(1); tick[k] = 1'b0;
    endtask

    task automatic p_gf(input int k, input logic w);
        lw[k] = w; gf[k] = 1'b1; cyc(1); gf[k] = 1'b0;
    endtask

    // starts in COUNT with countdown 3, ends in COUNT of the next game or OVER
    task automatic win_game(input logic w);
        repeat (3) p_tick(0);
        p_gf(0, w);
        cyc(2);
    endtask

    initial begin
        cyc(2);
        resetMatch = 1'b0;
        cyc(1);
        check("reset.state", int'(st[0]), 0);
        check("reset.p1", int'(p1[0]), 0);

        p_gf(0, 1'b1);
        check("idle_gf.state", int'(st[0]), 0);
        check("idle_gf.p2", int'(p2[0]), 0);

        p_start(0);
        check("load.gameReset", int'(grst[0]), 1);
        check("load.state", int'(st[0]), 1);
        cyc(1);
        check("count.start", int'(cd[0]), 3);
        check("count.grst_low", int'(grst[0]), 0);

        p_gf(0, 1'b0);
        check("count_gf.p1", int'(p1[0]), 0);
        check("count_gf.cd", int'(cd[0]), 3);
        p_tick(0);
        check("tick1.cd", int'(cd[0]), 2);
        p_start(0);
        check("count_start.cd", int'(cd[0]), 2);
        p_tick(0);
        check("tick2.cd", int'(cd[0]), 1);
        p_tick(0);
        check("tick3.cd", int'(cd[0]), 0);
        check("tick3.gameRun", int'(grun[0]), 1);

        p_gf(0, 1'b1);
        check("credit.p2", int'(p2[0]), 1);
        check("credit.p1", int'(p1[0]), 0);
        check("credit.gameRun", int'(grun[0]), 0);
        check("credit.state", int'(st[0]), 4);
        cyc(1);
        check("rearm.gameReset", int'(grst[0]), 1);
        cyc(1);
        check("rearm.cd", int'(cd[0]), 3);

        for (int i = 0; i < 7; i++) win_game(1'b0);
        check("over.p1", int'(p1[0]), 7);
        check("over.p2", int'(p2[0]), 1);
        check("over.matchOver", int'(mo[0]), 1);
        check("over.winner", int'(mw[0]), 0);
        p_tick(0);
        p_gf(0, 1'b0);
        check("over_frozen.p1", int'(p1[0]), 7);
        check("over_frozen.state", int'(st[0]), 5);
        p_start(0);
        check("restart.p1", int'(p1[0]), 0);
        check("restart.p2", int'(p2[0]), 0);
        check("restart.state", int'(st[0]), 1);
        check("restart.matchOver", int'(mo[0]), 0);
        cyc(1);

        for (int i = 0; i < 3; i++) win_game(1'b0);
        for (int i = 0; i < 2; i++) win_game(1'b1);
        repeat (3) p_tick(0);
        check("mid.gameRun", int'(grun[0]), 1);
        check("mid.p1", int'(p1[0]), 3);
        check("mid.p2", int'(p2[0]), 2);
        #2 resetMatch = 1'b1;
        #1;
        check("async.gameRun", int'(grun[0]), 0);
        check("async.p1", int'(p1[0]), 0);
        check("async.p2", int'(p2[0]), 0);
        check("async.state", int'(st[0]), 0);
        cyc(2);
        resetMatch = 1'b0;
        cyc(2);
        check("release.state", int'(st[0]), 0);
        p_tick(0);
        check("release_tick.state", int'(st[0]), 0);

        p_start(1);
        check("np.gameReset", int'(grst[1]), 1);
        check("np.load", int'(st[1]), 1);
        cyc(1);
        check("np.gameRun", int'(grun[1]), 1);
        check("np.state", int'(st[1]), 3);
        lw[1] = 1'b0; tick[1] = 1'b1; gf[1] = 1'b1;
        cyc(1);
        tick[1] = 1'b0; gf[1] = 1'b0;
        check("np.p1", int'(p1[1]), 1);
        check("np.p2", int'(p2[1]), 0);
        check("np.check", int'(st[1]), 4);
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
